// File: rtl/vend_pkg.sv
// vend_pkg: shared constants for the vending-machine controller slice.
//   - FSM state encoding (2-bit, kept as plain localparams so legacy
//     tooling that pokes at the state register keeps working)
//   - coin values in 10p units
package vend_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;  // no credit held
  localparam logic [1:0] S_CREDIT = 2'd1;  // 0 < credit < PRICE
  localparam logic [1:0] S_VEND   = 2'd2;  // dispensing the item this cycle
  localparam logic [1:0] S_CHANGE = 2'd3;  // paying out change coins

  localparam int C10 = 1;
  localparam int C20 = 2;
  localparam int C50 = 5;

endpackage

// File: rtl/vend_if.sv
// vend_if: customer-facing signal bundle of the vending controller.
//   master : drives coin10p/coin20p/coin50p/refund, observes the outputs
//   slave  : the controller; drives vend, ret10p, ret20p, coin_rej, busy,
//            credit[CREDIT_W-1:0]
interface vend_if #(
  parameter int CREDIT_W = 4
);
  logic                coin10p;
  logic                coin20p;
  logic                coin50p;
  logic                refund;
  logic                vend;
  logic                ret10p;
  logic                ret20p;
  logic                coin_rej;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin10p, coin20p, coin50p, refund,
    input  vend, ret10p, ret20p, coin_rej, busy, credit
  );

  modport slave (
    input  coin10p, coin20p, coin50p, refund,
    output vend, ret10p, ret20p, coin_rej, busy, credit
  );
endinterface

// File: rtl/vend_change.sv
// vend_change: greedy change dispenser.
//   clk, rst  : clock, synchronous active-high reset (drops pending change)
//   load      : capture load_val as the amount of change to pay out
//   load_val  : change amount in 10p units
//   ret20p    : return one 20p coin this cycle (change >= 2)
//   ret10p    : return one 10p coin this cycle (change == 1)
//   done      : the coin shown this cycle is the last one
module vend_change
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  output logic                ret10p,
  output logic                ret20p,
  output logic                done
);

  logic [CREDIT_W-1:0] chg;

  // Down-counter: each cycle pays the largest coin that fits.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg <= '0;
    end else if (load) begin
      chg <= load_val;
    end else if (chg >= CREDIT_W'(C20)) begin
      chg <= chg - CREDIT_W'(C20);
    end else begin
      chg <= '0;
    end
  end

  // Moore decodes; the two ret outputs are mutually exclusive by construction.
  assign ret20p = (chg >= CREDIT_W'(C20));
  assign ret10p = (chg == CREDIT_W'(C10));
  assign done   = (chg <= CREDIT_W'(C20));

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-operated vending controller.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : vend_if.slave
//     in  coin10p/coin20p/coin50p : one-cycle coin pulses (1/2/5 units)
//     in  refund                  : one-cycle refund request
//     out vend                    : one-cycle dispense pulse
//     out ret10p/ret20p           : one-cycle change-coin pulses
//     out coin_rej                : coin sampled on the previous edge rejected
//     out busy                    : high while vending or paying change
//     out credit                  : accepted credit in units
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 5,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 9
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);

  // Wide enough that credit + 50p can never wrap before the limit check.
  localparam int SUM_W = CREDIT_W + 3;

  logic [1:0]          state, state_nxt;
  logic [CREDIT_W-1:0] credit, credit_nxt;
  logic                coin_rej, rej_nxt;
  logic                chg_load;
  logic [CREDIT_W-1:0] chg_val;
  logic                chg_done;
  logic [1:0]          ncoins;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    sum;
  logic                open;
  logic                accept;

  always_comb begin
    ncoins = 2'(bus.coin10p) + 2'(bus.coin20p) + 2'(bus.coin50p);
    coin_val = '0;
    if (bus.coin50p)      coin_val = SUM_W'(C50);
    else if (bus.coin20p) coin_val = SUM_W'(C20);
    else if (bus.coin10p) coin_val = SUM_W'(C10);
    sum = SUM_W'(credit) + coin_val;

    open   = (state == S_IDLE) || (state == S_CREDIT);
    // Refund wins over any coin; simultaneous coins are all refused.
    accept = open && !bus.refund && (ncoins == 2'd1) &&
             (sum <= SUM_W'(MAX_CREDIT));
    rej_nxt = (ncoins != 2'd0) && !accept;

    state_nxt  = state;
    credit_nxt = credit;
    chg_load   = 1'b0;
    chg_val    = '0;
    case (state)
      S_IDLE, S_CREDIT: begin
        if (bus.refund) begin
          // Refund with zero credit (IDLE) has nothing to return.
          if (state == S_CREDIT) begin
            chg_load   = 1'b1;
            chg_val    = credit;
            credit_nxt = '0;
            state_nxt  = S_CHANGE;
          end
        end else if (accept) begin
          credit_nxt = CREDIT_W'(sum);
          state_nxt  = (sum >= SUM_W'(PRICE)) ? S_VEND : S_CREDIT;
        end
      end
      S_VEND: begin
        chg_load   = 1'b1;
        chg_val    = credit - CREDIT_W'(PRICE);
        credit_nxt = '0;
        state_nxt  = (credit == CREDIT_W'(PRICE)) ? S_IDLE : S_CHANGE;
      end
      S_CHANGE: begin
        if (chg_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      credit   <= '0;
      coin_rej <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit   <= credit_nxt;
      coin_rej <= rej_nxt;
    end
  end

  vend_change #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .clk      (clk),
    .rst      (rst),
    .load     (chg_load),
    .load_val (chg_val),
    .ret10p   (bus.ret10p),
    .ret20p   (bus.ret20p),
    .done     (chg_done)
  );

  assign bus.vend     = (state == S_VEND);
  assign bus.busy     = (state == S_VEND) || (state == S_CHANGE);
  assign bus.credit   = credit;
  assign bus.coin_rej = coin_rej;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scoreboard bench for vend_ctrl (PRICE=5, MAX_CREDIT=9).
// A queue-based reference model predicts each cycle's outputs; a monitor
// compares them one cycle at a time against the DUT.
module tb_vend_ctrl;

  localparam int PRICE = 5;
  localparam int CW    = 4;
  localparam int MAXC  = 9;

  typedef struct packed {
    logic          v;
    logic          r10;
    logic          r20;
    logic          rej;
    logic          busy;
    logic [CW-1:0] cr;
  } obs_t;

  typedef struct {
    bit v;
    bit r10;
    bit r20;
    int cr;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vend_if #(.CREDIT_W(CW)) bus ();

  vend_ctrl #(
    .PRICE      (PRICE),
    .CREDIT_W   (CW),
    .MAX_CREDIT (MAXC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  obs_t  exp_q[$];
  step_t plan[$];
  step_t cur;
  bit    cur_busy = 1'b0;
  int    m_credit = 0;
  int    n_vec    = 0;
  int    n_fail   = 0;
  bit    done     = 1'b0;

  // Greedy change as a list of future output cycles.
  task automatic push_change(input int amt);
    for (int i = 0; i < amt / 2; i++) plan.push_back('{0, 0, 1, 0});
    if (amt % 2 != 0) plan.push_back('{0, 1, 0, 0});
  endtask

  // Apply one cycle of inputs and predict the outputs after the next edge.
  task automatic drive(input bit c1, input bit c2, input bit c5,
                       input bit rf, input bit rs);
    int   n;
    int   val;
    bit   acc;
    bit   rej;
    obs_t e;
    @(negedge clk);
    bus.coin10p = c1;
    bus.coin20p = c2;
    bus.coin50p = c5;
    bus.refund  = rf;
    rst         = rs;
    n   = int'(c1) + int'(c2) + int'(c5);
    val = c5 ? 5 : (c2 ? 2 : (c1 ? 1 : 0));
    rej = 1'b0;
    if (rs) begin
      m_credit = 0;
      plan.delete();
      cur_busy = 1'b0;
    end else begin
      acc = !cur_busy && !rf && (n == 1) && (m_credit + val <= MAXC);
      rej = (n > 0) && !acc;
      if (!cur_busy && rf && m_credit > 0) begin
        push_change(m_credit);
        m_credit = 0;
      end else if (acc) begin
        m_credit += val;
        if (m_credit >= PRICE) begin
          plan.push_back('{1, 0, 0, m_credit});
          push_change(m_credit - PRICE);
          m_credit = 0;
        end
      end
      if (plan.size() > 0) begin
        cur      = plan.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur_busy = 1'b0;
      end
    end
    e.v    = cur_busy & cur.v;
    e.r10  = cur_busy & cur.r10;
    e.r20  = cur_busy & cur.r20;
    e.rej  = rej;
    e.busy = cur_busy;
    e.cr   = CW'(cur_busy ? cur.cr : m_credit);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0);
  endtask

  // Monitor: the DUT presents a full output vector every cycle.
  initial begin
    obs_t e;
    obs_t a;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.vend, bus.ret10p, bus.ret20p, bus.coin_rej, bus.busy, bus.credit};
        n_vec++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got vend=%b r10=%b r20=%b rej=%b busy=%b cr=%0d exp vend=%b r10=%b r20=%b rej=%b busy=%b cr=%0d",
                   $time, a.v, a.r10, a.r20, a.rej, a.busy, a.cr,
                   e.v, e.r10, e.r20, e.rej, e.busy, e.cr);
        end
      end
    end
  end

  initial begin
    int k;
    bus.coin10p = 1'b0;
    bus.coin20p = 1'b0;
    bus.coin50p = 1'b0;
    bus.refund  = 1'b0;

    // Reset, with a coin present that must be neither accepted nor flagged.
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    idle(2);
    // 50p: immediate vend, no change.
    drive(0, 0, 1, 0, 0);
    idle(2);
    // 20p, 20p, 10p: exact price.
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(2);
    // 20p, 20p, refund: two 20p returned.
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    idle(3);
    // 20p, 10p, 50p: vend then 20p + 10p change.
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    idle(4);
    // 20p, 20p, 50p: vend then two 20p; a coin arrives during change.
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(3);
    // Simultaneous coins, refund with a coin, refund in IDLE.
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    idle(2);
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 1, 1, 0);
    idle(2);
    // Reset during the first 20p of a 4-unit change.
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        drive(0, 0, 0, 0, 1);
      end else begin
        k = $urandom_range(0, 15);
        case (k)
          6, 7:    drive(1, 0, 0, 0, 0);
          8, 9:    drive(0, 1, 0, 0, 0);
          10, 11:  drive(0, 0, 1, 0, 0);
          12:      drive(1, 1, 0, 0, 0);
          13:      drive(0, 0, 0, 1, 0);
          14:      drive(0, 0, 1, 1, 0);
          15:      drive(1, 1, 1, 0, 0);
          default: drive(0, 0, 0, 0, 0);
        endcase
      end
    end
    idle(1);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
